// File: rtl/adder32_ctrl_pkg.sv
// adder32_ctrl_pkg: shared ALU function codes and controller state encoding.
package adder32_ctrl_pkg;
  localparam logic ALUFN_ADD = 1'b0;
  localparam logic ALUFN_SUB = 1'b1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/adder32.sv
// adder32: 32-bit add/subtract with zero, signed-overflow and negative flags.
module adder32
  import adder32_ctrl_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ALUFN,
  output logic [31:0] sum,
  output logic        Z,
  output logic        V,
  output logic        N
);
  logic [31:0] b_eff;
  always_comb begin
    b_eff = (ALUFN == ALUFN_SUB) ? ~B : B;
    sum   = A + b_eff + {31'b0, ALUFN};
    Z     = (sum == 32'b0);
    N     = sum[31];
    V     = (A[31] == b_eff[31]) && (sum[31] != A[31]);
  end
endmodule

// File: rtl/adder32_ctrl.sv
// adder32_ctrl: request/response wrapper around adder32 with accumulator and
// saturating overflow counter; one request in flight, two-cycle latency.
module adder32_ctrl
  import adder32_ctrl_pkg::*;
#(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_a,
  input  logic [31:0]          req_b,
  input  logic                 req_alufn,
  input  logic                 req_acc,
  input  logic                 acc_clr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_z,
  output logic                 rsp_v,
  output logic                 rsp_n,
  output logic [31:0]          acc,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);
  state_t                 state_q, state_d;
  logic [31:0]            op_a_q, op_a_d, op_b_q, op_b_d;
  logic                   alufn_q, alufn_d;
  logic [31:0]            sum_q, sum_d, acc_q, acc_d;
  logic                   z_q, z_d, v_q, v_d, n_q, n_d;
  logic [OVF_CNT_W-1:0]   ovf_q, ovf_d, ovf_base;
  logic [31:0]            add_sum;
  logic                   add_z, add_v, add_n;
  logic                   accept, commit;

  adder32 u_adder (
    .A     (op_a_q),
    .B     (op_b_q),
    .ALUFN (alufn_q),
    .sum   (add_sum),
    .Z     (add_z),
    .V     (add_v),
    .N     (add_n)
  );

  always_comb begin
    accept   = (state_q == IDLE) && req_valid;
    commit   = (state_q == EXEC);
    state_d  = (state_q == IDLE) ? (req_valid ? EXEC : IDLE) :
               (state_q == EXEC) ? RESP :
               (state_q == RESP) ? (rsp_ready ? IDLE : RESP) : IDLE;
    // a same-cycle clear must zero an accumulator operand being captured
    op_a_d   = accept ? (req_acc ? (acc_clr ? 32'b0 : acc_q) : req_a) : op_a_q;
    op_b_d   = accept ? req_b : op_b_q;
    alufn_d  = accept ? req_alufn : alufn_q;
    sum_d    = commit ? add_sum : sum_q;
    z_d      = commit ? add_z : z_q;
    v_d      = commit ? add_v : v_q;
    n_d      = commit ? add_n : n_q;
    // commit beats clear: the count restarts from zero but still counts this V
    ovf_base = acc_clr ? '0 : ovf_q;
    ovf_d    = (commit && add_v) ? ((&ovf_base) ? ovf_base : ovf_base + 1'b1) : ovf_base;
    acc_d    = commit ? add_sum : (acc_clr ? 32'b0 : acc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      alufn_q <= ALUFN_ADD;
      sum_q   <= '0;
      z_q     <= 1'b1;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      alufn_q <= alufn_d;
      sum_q   <= sum_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_z     = z_q;
  assign rsp_v     = v_q;
  assign rsp_n     = n_q;
  assign acc       = acc_q;
  assign ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_adder32_ctrl.sv
// tb_adder32_ctrl: directed vector table plus backpressure, reset and saturation sequences.
module tb_adder32_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_alufn = 1'b0, req_acc = 1'b0, acc_clr = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, rsp_z, rsp_v, rsp_n;
  logic [31:0] rsp_sum, acc;
  logic [7:0]  ovf_cnt;
  int          checks = 0, failures = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        alufn, acc_sel, clr_acc, clr_exec;
    logic [31:0] sum;
    logic        z, v, n;
    logic [31:0] acc;
    logic [7:0]  ovf;
  } vec_t;
  vec_t vecs[11];

  adder32_ctrl #(.OVF_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_alufn(req_alufn), .req_acc(req_acc),
    .acc_clr(acc_clr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n),
    .acc(acc), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({nm, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, " rsp_sum"}, rsp_sum, 32'd0);
    chk({nm, " flags zvn"}, {29'b0, rsp_z, rsp_v, rsp_n}, 32'b100);
    chk({nm, " acc"}, acc, 32'd0);
    chk({nm, " ovf_cnt"}, {24'b0, ovf_cnt}, 32'd0);
  endtask

  task automatic do_txn(input int idx, input vec_t t);
    string s;
    s = $sformatf("vec%0d", idx);
    @(negedge clk);
    req_a = t.a; req_b = t.b; req_alufn = t.alufn; req_acc = t.acc_sel;
    acc_clr = t.clr_acc; req_valid = 1'b1;
    chk({s, " req_ready"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; acc_clr = t.clr_exec;
    chk({s, " rsp_valid@t+1"}, {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    acc_clr = 1'b0;
    chk({s, " rsp_valid@t+2"}, {31'b0, rsp_valid}, 32'd1);
    chk({s, " sum"}, rsp_sum, t.sum);
    chk({s, " flags zvn"}, {29'b0, rsp_z, rsp_v, rsp_n}, {29'b0, t.z, t.v, t.n});
    chk({s, " acc"}, acc, t.acc);
    chk({s, " ovf_cnt"}, {24'b0, ovf_cnt}, {24'b0, t.ovf});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_ovf_txn();
    @(negedge clk);
    req_a = 32'h7FFF_FFFF; req_b = 32'd1; req_alufn = 1'b0; req_acc = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    //            a             b             fn    acc   clrA  clrX  sum           z     v     n     acc           ovf
    vecs[0]  = '{32'h55,       32'h33,       1'b0, 1'b0, 1'b0, 1'b0, 32'h88,       1'b0, 1'b0, 1'b0, 32'h88,       8'd0};
    vecs[1]  = '{32'h55,       32'h33,       1'b1, 1'b0, 1'b0, 1'b0, 32'h22,       1'b0, 1'b0, 1'b0, 32'h22,       8'd0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h80000000, 8'd1};
    vecs[3]  = '{32'h80000000, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 8'd2};
    vecs[4]  = '{32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        8'd2};
    vecs[5]  = '{32'hDEAD,     32'h5,        1'b0, 1'b1, 1'b0, 1'b0, 32'h5,        1'b0, 1'b0, 1'b0, 32'h5,        8'd2};
    vecs[6]  = '{32'hBEEF,     32'h7,        1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 8'd2};
    vecs[7]  = '{32'h1234,     32'h3,        1'b0, 1'b1, 1'b1, 1'b0, 32'h3,        1'b0, 1'b0, 1'b0, 32'h3,        8'd0};
    vecs[8]  = '{32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h80000000, 8'd1};
    vecs[9]  = '{32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h80000000, 8'd1};
    vecs[10] = '{32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 32'h2,        8'd0};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post-reset idle");

    for (int i = 0; i < 11; i++) do_txn(i, vecs[i]);

    // backpressure: result held, new requests dropped
    @(negedge clk);
    req_a = 32'h10; req_b = 32'h20; req_alufn = 1'b0; req_acc = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d req_ready", i), {31'b0, req_ready}, 32'd0);
      chk($sformatf("bp%0d rsp_sum", i), rsp_sum, 32'h30);
      req_valid = 1'b1; req_a = 32'hF00 + i; req_b = 32'h1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp held rsp_sum", rsp_sum, 32'h30);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (3) begin
      chk("bp dropped rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    chk("bp dropped acc", acc, 32'h30);

    // reset asserted while in EXEC
    req_a = 32'h7FFF_FFFF; req_b = 32'd1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst in exec");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("after rst%0d rsp_valid", i), {31'b0, rsp_valid}, 32'd0);
      chk($sformatf("after rst%0d ovf_cnt", i), {24'b0, ovf_cnt}, 32'd0);
    end

    // overflow counter saturates and does not wrap
    for (int i = 0; i < 254; i++) run_ovf_txn();
    chk("ovf 254", {24'b0, ovf_cnt}, 32'd254);
    run_ovf_txn();
    chk("ovf sat 255", {24'b0, ovf_cnt}, 32'd255);
    run_ovf_txn();
    chk("ovf no wrap", {24'b0, ovf_cnt}, 32'd255);
    chk("ovf last v", {31'b0, rsp_v}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
